// File: rtl/sr_cpu_pkg.sv
// sr_cpu_pkg: shared encodings for the sr_cpu_core multicycle CPU.
// Holds instruction opcode/op constants, memory command codes, the control
// FSM state enum, one-hot vsel/nsel codes and the control/decode structs.
package sr_cpu_pkg;
    localparam logic [2:0] OPC_LDR  = 3'b011;
    localparam logic [2:0] OPC_STR  = 3'b100;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_HALT = 3'b111;

    localparam logic [1:0] OP_MOVR = 2'b00;
    localparam logic [1:0] OP_MOVI = 2'b10;
    localparam logic [1:0] OP_CMP  = 2'b01;
    localparam logic [1:0] OP_MVN  = 2'b11;
    localparam logic [1:0] OP_MEM  = 2'b00;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    localparam logic [3:0] VSEL_MDATA = 4'b0001;
    localparam logic [3:0] VSEL_IMM8  = 4'b0010;
    localparam logic [3:0] VSEL_PC    = 4'b0100;
    localparam logic [3:0] VSEL_C     = 4'b1000;

    localparam logic [2:0] NSEL_RN = 3'b001;
    localparam logic [2:0] NSEL_RD = 3'b010;
    localparam logic [2:0] NSEL_RM = 3'b100;

    typedef enum logic [4:0] {
        S_RST, S_IF1, S_IF2, S_UPC, S_DEC, S_WIMM, S_GETA, S_GETB, S_EXEC,
        S_WRD, S_CMPS, S_ADDR, S_LDA, S_MRD1, S_MRD2, S_SCPY, S_MWR, S_HALT
    } state_e;

    // Datapath controls. use_ins_alu: take ALU op and shift from the
    // instruction; otherwise the ALU adds and the shifter passes through.
    typedef struct packed {
        logic       load_a, load_b, load_c, load_s;
        logic       asel, bsel, use_ins_alu, write;
        logic [2:0] nsel;
        logic [3:0] vsel;
    } dp_ctrl_t;

    typedef struct packed {
        logic       load_ir, load_pc, load_da, use_da, halt;
        logic [1:0] mem_cmd;
        dp_ctrl_t   dp;
    } ctrl_t;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [1:0]  op;
        logic [2:0]  rn, rd, rm;
        logic [1:0]  shift;
        logic [15:0] sximm8, sximm5;
    } ins_t;
endpackage

// File: rtl/datapath.sv
// datapath: 8x16 register file, B-path shifter, ALU, A/B/C latches, flags.
// Ports: clk, reset (sync, active-low), ctrl (datapath controls), rn/rd/rm,
// op/shift, sximm8/sximm5 (instruction fields), mdata (memory word), pc,
// c (C register out), n/v/z (status flags out).
module datapath import sr_cpu_pkg::*; (
    input  logic        clk,
    input  logic        reset,
    input  dp_ctrl_t    ctrl,
    input  logic [2:0]  rn,
    input  logic [2:0]  rd,
    input  logic [2:0]  rm,
    input  logic [1:0]  op,
    input  logic [1:0]  shift,
    input  logic [15:0] sximm8,
    input  logic [15:0] sximm5,
    input  logic [15:0] mdata,
    input  logic [8:0]  pc,
    output logic [15:0] c,
    output logic        n,
    output logic        v,
    output logic        z
);
    logic [15:0] rf [8];
    logic [15:0] a, b, rdata, wdata, bsh, ain, bin, res;
    logic [2:0]  rnum;
    logic [1:0]  sh, aop;

    always_comb begin
        rnum  = ({3{ctrl.nsel[0]}} & rn) | ({3{ctrl.nsel[1]}} & rd) | ({3{ctrl.nsel[2]}} & rm);
        wdata = ({16{ctrl.vsel[0]}} & mdata) | ({16{ctrl.vsel[1]}} & sximm8)
              | ({16{ctrl.vsel[2]}} & {7'b0, pc}) | ({16{ctrl.vsel[3]}} & c);
        rdata = rf[rnum];
        // outside EXEC/CMPS the instruction's shift bits may be imm5 bits
        sh    = ctrl.use_ins_alu ? shift : 2'b00;
        aop   = ctrl.use_ins_alu ? op : 2'b00;
        case (sh)
            2'b01:   bsh = {b[14:0], 1'b0};
            2'b10:   bsh = {1'b0, b[15:1]};
            2'b11:   bsh = {b[15], b[15:1]};
            default: bsh = b;
        endcase
        ain = ctrl.asel ? 16'h0000 : a;
        bin = ctrl.bsel ? sximm5 : bsh;
        case (aop)
            2'b00:   res = ain + bin;
            2'b01:   res = ain - bin;
            2'b10:   res = ain & bin;
            default: res = ~bin;
        endcase
    end

    // gated by reset so a reset edge landing on a write state writes nothing
    always_ff @(posedge clk) begin
        if (reset && ctrl.write) rf[rnum] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            a <= '0; b <= '0; c <= '0;
            n <= 1'b0; v <= 1'b0; z <= 1'b0;
        end else begin
            if (ctrl.load_a) a <= rdata;
            if (ctrl.load_b) b <= rdata;
            if (ctrl.load_c) c <= res;
            if (ctrl.load_s) begin
                z <= (res == 16'h0000);
                n <= res[15];
                v <= (ain[15] ^ bin[15]) & (res[15] ^ ain[15]);
            end
        end
    end
endmodule

// File: rtl/fsm.sv
// fsm: control state machine. Controls are registered: on every edge the
// controls for the state being entered are loaded alongside the state.
// Ports: clk, reset (sync, active-low), opcode/op (from IR), ctrl (out).
module fsm import sr_cpu_pkg::*; (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output ctrl_t      ctrl
);
    state_e state, nxt;

    function automatic state_e next_of(state_e s, logic [2:0] opc, logic [1:0] o);
        case (s)
            S_RST:  return S_IF1;
            S_IF1:  return S_IF2;
            S_IF2:  return S_UPC;
            S_UPC:  return S_DEC;
            S_DEC:
                case (opc)
                    OPC_MOV:  return (o == OP_MOVI) ? S_WIMM : (o == OP_MOVR) ? S_GETB : S_IF1;
                    OPC_ALU:  return (o == OP_MVN) ? S_GETB : S_GETA;
                    OPC_LDR,
                    OPC_STR:  return (o == OP_MEM) ? S_GETA : S_IF1;
                    OPC_HALT: return S_HALT;
                    default:  return S_IF1;
                endcase
            S_GETA: return (opc == OPC_LDR || opc == OPC_STR) ? S_ADDR : S_GETB;
            S_GETB: return (opc == OPC_STR) ? S_SCPY : (o == OP_CMP && opc == OPC_ALU) ? S_CMPS : S_EXEC;
            S_EXEC: return S_WRD;
            S_ADDR: return S_LDA;
            S_LDA:  return (opc == OPC_LDR) ? S_MRD1 : S_GETB;
            S_MRD1: return S_MRD2;
            S_SCPY: return S_MWR;
            S_HALT: return S_HALT;
            default: return S_IF1;  // WIMM, WRD, CMPS, MRD2, MWR
        endcase
    endfunction

    function automatic ctrl_t ctrl_for(state_e s, logic [2:0] opc, logic [1:0] o);
        ctrl_t c;
        c = '0;
        case (s)
            S_IF1:  c.mem_cmd = MEM_READ;
            S_IF2:  begin c.mem_cmd = MEM_READ; c.load_ir = 1'b1; end
            S_UPC:  c.load_pc = 1'b1;
            S_WIMM: begin c.dp.write = 1'b1; c.dp.nsel = NSEL_RN; c.dp.vsel = VSEL_IMM8; end
            S_GETA: begin c.dp.load_a = 1'b1; c.dp.nsel = NSEL_RN; end
            // STR reuses GETB to fetch the store data from Rd
            S_GETB: begin c.dp.load_b = 1'b1; c.dp.nsel = (opc == OPC_STR) ? NSEL_RD : NSEL_RM; end
            S_EXEC: begin
                c.dp.load_c = 1'b1;
                c.dp.use_ins_alu = 1'b1;
                c.dp.asel = (opc == OPC_MOV) || (o == OP_MVN);
            end
            S_WRD:  begin c.dp.write = 1'b1; c.dp.nsel = NSEL_RD; c.dp.vsel = VSEL_C; end
            S_CMPS: begin c.dp.load_s = 1'b1; c.dp.use_ins_alu = 1'b1; end
            S_ADDR: begin c.dp.load_c = 1'b1; c.dp.bsel = 1'b1; end
            S_LDA:  c.load_da = 1'b1;
            S_MRD1: begin c.mem_cmd = MEM_READ; c.use_da = 1'b1; end
            S_MRD2: begin
                c.mem_cmd = MEM_READ; c.use_da = 1'b1;
                c.dp.write = 1'b1; c.dp.nsel = NSEL_RD; c.dp.vsel = VSEL_MDATA;
            end
            S_SCPY: begin c.dp.load_c = 1'b1; c.dp.asel = 1'b1; end
            S_MWR:  begin c.mem_cmd = MEM_WRITE; c.use_da = 1'b1; end
            S_HALT: c.halt = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    always_comb nxt = next_of(state, opcode, op);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_RST;
            ctrl  <= '0;
        end else begin
            state <= nxt;
            ctrl  <= ctrl_for(nxt, opcode, op);
        end
    end
endmodule

// File: rtl/ins_decoder.sv
// ins_decoder: combinational field extraction from the instruction register.
// Ports: ir (instruction word in), ins (decoded fields, sign-extended imms out).
module ins_decoder import sr_cpu_pkg::*; (
    input  logic [15:0] ir,
    output ins_t        ins
);
    always_comb begin
        ins.opcode = ir[15:13];
        ins.op     = ir[12:11];
        ins.rn     = ir[10:8];
        ins.rd     = ir[7:5];
        ins.shift  = ir[4:3];
        ins.rm     = ir[2:0];
        ins.sximm8 = {{8{ir[7]}}, ir[7:0]};
        ins.sximm5 = {{11{ir[4]}}, ir[4:0]};
    end
endmodule

// File: rtl/sr_cpu_core.sv
// sr_cpu_core: multicycle 16-bit RISC core. Holds PC, IR, data-address
// register and the memory address mux; instantiates decoder, fsm, datapath.
// Ports: clk, reset (sync, active-low), read_data (combinational memory
// read), mem_cmd/mem_addr/write_data (memory request), out (C register),
// N/V/Z (flags), w (halted).
module sr_cpu_core import sr_cpu_pkg::*; (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] read_data,
    output logic [1:0]  mem_cmd,
    output logic [8:0]  mem_addr,
    output logic [15:0] write_data,
    output logic [15:0] out,
    output logic        N,
    output logic        V,
    output logic        Z,
    output logic        w
);
    logic [15:0] ir, c;
    logic [8:0]  pc, da;
    ins_t        ins;
    ctrl_t       ctrl;

    ins_decoder u_dec (.ir(ir), .ins(ins));

    fsm u_fsm (
        .clk(clk), .reset(reset), .opcode(ins.opcode), .op(ins.op), .ctrl(ctrl)
    );

    datapath u_dp (
        .clk(clk), .reset(reset), .ctrl(ctrl.dp),
        .rn(ins.rn), .rd(ins.rd), .rm(ins.rm), .op(ins.op), .shift(ins.shift),
        .sximm8(ins.sximm8), .sximm5(ins.sximm5), .mdata(read_data), .pc(pc),
        .c(c), .n(N), .v(V), .z(Z)
    );

    // PC increment wraps 511 -> 0 by width
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc <= '0; ir <= '0; da <= '0;
        end else begin
            if (ctrl.load_pc) pc <= pc + 9'd1;
            if (ctrl.load_ir) ir <= read_data;
            if (ctrl.load_da) da <= c[8:0];
        end
    end

    assign mem_cmd    = ctrl.mem_cmd;
    assign mem_addr   = ctrl.use_da ? da : pc;
    assign write_data = c;
    assign out        = c;
    assign w          = ctrl.halt;
endmodule

// File: tb/tb_sr_cpu_core.sv
// tb_sr_cpu_core: directed programs with a write scoreboard. Expected stores
// are queued by the stimulus process; a negedge monitor pops and compares
// each cycle the core issues a write.
module tb_sr_cpu_core;
    logic        clk, reset;
    logic [15:0] read_data, write_data, out;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic        N, V, Z, w;

    int checks = 0;
    int errors = 0;

    typedef struct packed { logic [8:0] a; logic [15:0] d; } wr_t;
    wr_t exp_q[$];

    logic [15:0] mem [512];
    logic        load_req;
    logic        prog_sel;

    logic [15:0] prog1 [0:20] = '{
        16'hD007, 16'hD102, 16'hA148, 16'hA800, 16'hA900, 16'h8143, 16'h6163,
        16'h8170, 16'hB881, 16'hC0BC, 16'hC0D4, 16'hB5E6, 16'h81F1, 16'h81B2,
        16'hAE04, 16'h0000, 16'hD080, 16'hC048, 16'h835F, 16'h8113, 16'hE000};
    logic [15:0] prog2 [0:3] = '{16'hD007, 16'hD102, 16'hA900, 16'h8103};

    sr_cpu_core dut (
        .clk(clk), .reset(reset), .read_data(read_data), .mem_cmd(mem_cmd),
        .mem_addr(mem_addr), .write_data(write_data), .out(out),
        .N(N), .V(V), .Z(Z), .w(w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign read_data = mem[mem_addr];

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 512; i++)
                mem[i] <= (prog_sel == 1'b0) ? ((i < 21) ? prog1[i[4:0]] : 16'h0000)
                                             : ((i < 4)  ? prog2[i[1:0]] : 16'h0000);
        end else if (mem_cmd == 2'b10) begin
            mem[mem_addr] <= write_data;
        end
    end

    // scoreboard monitor
    always @(negedge clk) begin
        wr_t e;
        if (mem_cmd == 2'b10) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write", mem_addr, write_data);
            end else begin
                e = exp_q.pop_front();
                if (mem_addr !== e.a || write_data !== e.d) begin
                    errors++;
                    $display("FAIL store: got addr=%0d data=%h expected addr=%0d data=%h",
                             mem_addr, write_data, e.a, e.d);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_wr(input logic [8:0] a, input logic [15:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // waits for the first fetch cycle (IF1) of address a
    task automatic wait_fetch(input logic [8:0] a);
        int n;
        n = 0;
        while (!(mem_cmd == 2'b01 && mem_addr == a) && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) begin
            checks++;
            errors++;
            $display("FAIL fetch_timeout: no fetch of %0d within 400 cycles", a);
        end
    endtask

    initial begin
        int n;
        int bad;
        reset = 1'b0; load_req = 1'b1; prog_sel = 1'b0;
        tick();
        load_req = 1'b0;
        chk("rst_mem_cmd", 32'(mem_cmd), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_w", 32'(w), 32'h0);
        chk("rst_out", 32'(out), 32'h0);
        chk("rst_flags", 32'({N, V, Z}), 32'h0);

        push_wr(9'd5,   16'h0010);
        push_wr(9'd498, 16'h0010);
        push_wr(9'd499, 16'h7FFE);
        push_wr(9'd500, 16'hFFFE);
        push_wr(9'd15,  16'hFF00);
        push_wr(9'd501, 16'hFF80);

        reset = 1'b1;
        tick();
        chk("if1_mem_cmd", 32'(mem_cmd), 32'h1);
        chk("if1_mem_addr", 32'(mem_addr), 32'h0);

        wait_fetch(9'd3);
        chk("add_out", 32'(out), 32'h0010);
        wait_fetch(9'd4);
        chk("cmp_eq_flags", 32'({N, V, Z}), 32'b001);
        chk("cmp_eq_out", 32'(out), 32'h0010);
        wait_fetch(9'd5);
        chk("cmp_neg_flags", 32'({N, V, Z}), 32'b100);
        chk("cmp_neg_out", 32'(out), 32'h0010);
        wait_fetch(9'd15);
        chk("cmp_ovf_flags", 32'({N, V, Z}), 32'b110);
        chk("cmp_ovf_out", 32'(out), 32'hFFFE);

        n = 0;
        while (w !== 1'b1 && n < 400) begin tick(); n++; end
        chk("halt_reached", 32'(w), 32'h1);
        chk("halt_mem_cmd", 32'(mem_cmd), 32'h0);
        chk("halt_pc", 32'(mem_addr), 32'd21);
        bad = 0;
        repeat (20) begin
            tick();
            if (mem_addr !== 9'd21 || mem_cmd !== 2'b00 || w !== 1'b1) bad++;
        end
        chk("halt_hold_bad_cycles", 32'(bad), 32'h0);
        chk("halt_out", 32'(out), 32'hFF80);
        chk("halt_flags", 32'({N, V, Z}), 32'b110);
        chk("stores_pending", 32'(exp_q.size()), 32'h0);

        reset = 1'b0;
        tick();
        chk("hrst_w", 32'(w), 32'h0);
        chk("hrst_mem_addr", 32'(mem_addr), 32'h0);
        chk("hrst_mem_cmd", 32'(mem_cmd), 32'h0);
        chk("hrst_out", 32'(out), 32'h0);
        chk("hrst_flags", 32'({N, V, Z}), 32'h0);
        reset = 1'b1;
        tick();
        chk("resume_mem_cmd", 32'(mem_cmd), 32'h1);
        chk("resume_mem_addr", 32'(mem_addr), 32'h0);

        // reset landing on the write cycle of a store
        reset = 1'b0; prog_sel = 1'b1; load_req = 1'b1;
        tick();
        load_req = 1'b0;
        reset = 1'b1;
        push_wr(9'd5, 16'h0007);
        n = 0;
        while (mem_cmd !== 2'b10 && n < 200) begin tick(); n++; end
        chk("abort_mwr_seen", 32'(mem_cmd), 32'h2);
        chk("abort_pre_flags", 32'({N, V, Z}), 32'b100);
        reset = 1'b0;
        tick();
        chk("abort_mem_cmd", 32'(mem_cmd), 32'h0);
        chk("abort_out", 32'(out), 32'h0);
        chk("abort_flags", 32'({N, V, Z}), 32'h0);
        chk("abort_w", 32'(w), 32'h0);
        bad = 0;
        repeat (3) begin
            tick();
            if (mem_cmd !== 2'b00) bad++;
        end
        chk("abort_no_further_cmd", 32'(bad), 32'h0);
        chk("abort_stores_pending", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
